// File: rtl/irq_sched_if.sv
// Bus bundle between the interrupt scheduler and the pipeline/config decode.
// master = pipeline/software side, slave = scheduler side.
interface irq_sched_if #(
    parameter int N_IRQ = 8
) ();
    logic [N_IRQ-1:0] irq_in;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             int_req;
    logic             int_ack;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [3:0]       int_cause;
    logic             in_service;
    logic             eret;

    modport master (
        output irq_in, cfg_we, cfg_addr, cfg_wdata, int_ack, eret,
        input  cfg_rdata, int_req, redirect_valid, redirect_pc, int_cause, in_service
    );

    modport slave (
        input  irq_in, cfg_we, cfg_addr, cfg_wdata, int_ack, eret,
        output cfg_rdata, int_req, redirect_valid, redirect_pc, int_cause, in_service
    );
endinterface

// File: rtl/irq_sched.sv
// Edge-capturing, fixed-priority interrupt scheduler: pends rising edges, picks the
// lowest eligible line and walks the pipeline through flush, redirect and service.
module irq_sched #(
    parameter int N_IRQ = 8
) (
    input  logic       clk,
    input  logic       rst,
    irq_sched_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_VEC  = 2'd2,
        ST_SERV = 2'd3
    } state_e;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_BASE = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic [N_IRQ-1:0] mask_q, mask_d, pend_q, pend_d, prev_q;
    logic [N_IRQ-1:0] rise_s, sw_clr_s, hw_clr_s, elig_s, cause_hot_s;
    logic [31:0]      base_q, base_d, rdata_s;
    logic             gie_q, gie_d;
    logic [3:0]       cause_q, cause_d, cause_out_s;
    state_e           state_q, state_d;

    function automatic logic [3:0] pick_winner(input logic [N_IRQ-1:0] v);
        logic [3:0] w;
        w = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                w = 4'(i);
            end
        end
        return w;
    endfunction

    // A fresh edge is OR-ed in last so it beats any same-cycle clear.
    assign rise_s      = bus.irq_in & ~prev_q;
    assign cause_hot_s = N_IRQ'(1'b1) << cause_q;
    assign sw_clr_s    = (bus.cfg_we && (bus.cfg_addr == A_PEND)) ? bus.cfg_wdata[N_IRQ-1:0] : '0;
    assign hw_clr_s    = (state_q == ST_VEC) ? cause_hot_s : '0;
    assign pend_d      = (pend_q & ~(sw_clr_s | hw_clr_s)) | rise_s;
    assign elig_s      = pend_q & mask_q & {N_IRQ{gie_q}};

    // Software-visible configuration register updates.
    always_comb begin
        mask_d = mask_q;
        base_d = base_q;
        gie_d  = gie_q;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                A_MASK:  mask_d = bus.cfg_wdata[N_IRQ-1:0];
                A_BASE:  base_d = bus.cfg_wdata;
                A_CTRL:  gie_d  = bus.cfg_wdata[0];
                default: mask_d = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end
    end

    // Scheduler next state; the winner is only sampled when leaving IDLE.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != '0) begin
                    state_d = ST_REQ;
                    cause_d = pick_winner(elig_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    state_d = ST_VEC;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_VEC:  state_d = ST_SERV;
            ST_SERV: begin
                if (bus.eret) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERV;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            base_q  <= 32'd0;
            gie_q   <= 1'b0;
            cause_q <= 4'd0;
            state_q <= ST_IDLE;
        end else begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            prev_q  <= bus.irq_in;
            base_q  <= base_d;
            gie_q   <= gie_d;
            cause_q <= cause_d;
            state_q <= state_d;
        end
    end

    // Register read mux.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.cfg_addr)
            A_MASK:  rdata_s = 32'(mask_q);
            A_PEND:  rdata_s = 32'(pend_q);
            A_BASE:  rdata_s = base_q;
            A_CTRL:  rdata_s = {23'd0, bus.in_service, cause_out_s, 3'd0, gie_q};
            default: rdata_s = 32'd0;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign cause_out_s        = (state_q != ST_IDLE) ? cause_q : 4'd0;
    assign bus.int_cause      = cause_out_s;
    assign bus.int_req        = (state_q == ST_REQ);
    assign bus.redirect_valid = (state_q == ST_VEC);
    assign bus.in_service     = (state_q == ST_SERV);
    assign bus.redirect_pc    = (state_q == ST_VEC) ? (base_q + {26'd0, cause_q, 2'd0}) : 32'd0;
    assign bus.cfg_rdata      = rdata_s;
endmodule

// File: doc/irq_sched.md
# irq_sched

Interrupt scheduler for the pipelined CPU. It latches edge-triggered interrupt lines into a pending register and applies a software mask plus a global enable. It picks one winner by fixed priority and sequences the pipeline through flush request, acknowledge and PC redirect. It then holds the in-service state until the handler's `eret`. Software configures it through a small register port driven by the data-memory address decode.

## Interface
Parameters:
- `N_IRQ`, 8: number of interrupt lines, 1..16; line 0 has the highest priority.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `irq_in`, in, N_IRQ: raw interrupt lines, already synchronous to `clk`.
- `cfg_we`, in, 1: config write strobe.
- `cfg_addr`, in, 2: register select. 0 = MASK, 1 = PEND (write-1-to-clear), 2 = BASE, 3 = CTRL (bit0 = GIE; read bits 7:4 = service id, bit 8 = in_service).
- `cfg_wdata`, in, 32: config write data.
- `cfg_rdata`, out, 32: combinational read of the register at `cfg_addr`; unused bits read 0.
- `int_req`, out, 1: request to the hazard unit to flush and save EPC.
- `int_ack`, in, 1: pipeline has flushed and EPC is captured. Sampled only while `int_req`=1.
- `redirect_valid`, out, 1: one-cycle pulse; the fetch stage loads `redirect_pc`.
- `redirect_pc`, out, 32: BASE + (id << 2).
- `int_cause`, out, 4: winning id; held from the REQ state until the return to IDLE.
- `in_service`, out, 1: high while a handler runs.
- `eret`, in, 1: handler-return pulse from the decode stage.

## Operation
Reset values:
- All registers 0: MASK, PEND, BASE, GIE, `irq_prev`, FSM = IDLE.
- All outputs 0.

Edge capture:
- `irq_prev` <= `irq_in` every cycle.
- `PEND[i]` is set at a rising edge of `clk` when `irq_in[i]` & ~`irq_prev[i]`.
- A set always wins over any same-cycle clear (software write-1-to-clear or VEC auto-clear).

Eligibility:
- elig = PEND & MASK & {N_IRQ{GIE}}.
- The winner is the lowest-index set bit of elig.

FSM states:
- **IDLE**
  - If elig != 0: latch winner into `int_cause` and go to REQ.
  - Otherwise stay.
- **REQ**
  - `int_req`=1.
  - The winner is frozen: higher-priority arrivals, MASK writes and GIE clears do not change or cancel it.
  - When `int_ack`=1: go to VEC.
- **VEC** (exactly one cycle)
  - `redirect_valid`=1 and `redirect_pc` valid.
  - Clear `PEND[int_cause]` unless a new edge arrives on that line in the same cycle.
  - Go to SERV.
- **SERV**
  - `in_service`=1; no nesting.
  - When `eret`=1: go to IDLE.
  - Pending lines wait.

Other rules:
- `eret` outside SERV is ignored.
- `int_ack` outside REQ is ignored.
- Config writes are accepted in every state and take effect next cycle. BASE is sampled in VEC, so a BASE write during REQ affects the redirect.
- `redirect_pc` is 32-bit wrap-around addition. It is driven only during VEC and is 0 otherwise.

## Timing
- Rising edge of `irq_in[i]` first sampled at edge t: PEND[i]=1 after t, FSM enters REQ at t+1, `int_req` is high in cycle t+1..t+2.
- Latency from sampled edge to `int_req` is 2 edges, when the line is unmasked, GIE=1 and the FSM is in IDLE.
- `int_ack` seen at edge a: VEC is the cycle after a, then SERV.
- `eret` at edge e: IDLE after e. A remaining eligible pending line re-enters REQ one edge later; there is no idle gap requirement.
- Asserting `rst` at any point, including REQ or VEC, forces IDLE and drops `int_req`, `redirect_valid` and `in_service` immediately, without waiting for a clock edge.
- A line held high gives only one PEND set. A new low-to-high transition is required to re-pend.

## Test plan
1. **Reset and idle.** Reset, then MASK=0xFF, GIE=1, BASE=0x100. Pulse `irq_in[3]`.
   - `int_req` after 2 edges.
   - Ack gives `redirect_valid` for 1 cycle with `redirect_pc`=0x10C and `int_cause`=3.
   - PEND[3] cleared.
2. **Priority.** Lines 5 and 2 rise in the same cycle.
   - Winner 2 (`redirect_pc`=BASE+8).
   - After `eret`, line 5 is serviced (`redirect_pc`=BASE+0x14) with no extra pulse.
3. **Frozen winner.** Line 6 is in REQ; line 0 rises before `int_ack`.
   - `int_cause` stays 6 and redirect goes to BASE+0x18.
   - Line 0 is serviced after `eret`.
4. **Masking and enable.**
   - MASK=0xFE with line 0 pulsed: PEND=0x01, `int_req` stays 0.
   - Writing MASK=0xFF triggers the request.
   - With GIE=0 no request is made; PEND remains readable at addr 1.
5. **Set-vs-clear race.**
   - Write PEND=0x08 (W1C) in the same cycle line 3 rises: PEND[3] stays 1.
   - New edge on the serviced line during VEC: PEND stays set.
6. **Reset mid-operation.** Assert `rst` during REQ and during SERV.
   - All outputs are 0 within the same cycle.
   - After release, no request is made until a new edge arrives.
